// File: rtl/bias_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// bias_ctrl_pkg : shared types and helpers for the bias buffer controller
// Rev 1.0
// ============================================================================
package bias_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int unsigned min_lanes(input int unsigned remaining,
                                              input int unsigned lanes);
        return (remaining < lanes) ? remaining : lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// rd_tag_pipe : DEPTH-stage shift register of {valid, lane index} tracking
//               BRAM reads in flight; synchronous flush clears all valids.
// Rev 1.0
// ============================================================================
module rd_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             drained
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= push;
            r_idx[0]   <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_idx   = r_idx[DEPTH-1];

    // Drained: once the output stage is captured this cycle, nothing remains.
    generate
        if (DEPTH == 1) begin : g_drain_single
            assign drained = !push;
        end else begin : g_drain_multi
            assign drained = !push && !(|r_valid[DEPTH-2:0]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bias_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// bias_buffer_ctrl : streams bias words FIFO->BRAM (write) or fetches LANES-wide
//                    groups BRAM->datapath with latency-tolerant tagging (read).
// Rev 1.0
// ============================================================================
module bias_buffer_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int LANES  = 4,
    parameter int RD_LAT = 2,
    parameter int CH_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [CH_W-1:0]         ch_count,
    input  logic                    abort,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic [DATA_W-1:0]       bram_wdata,
    input  logic [DATA_W-1:0]       bram_rdata,
    output logic [LANES*DATA_W-1:0] bias_vec,
    output logic                    bias_valid,
    input  logic                    bias_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int N_W   = $clog2(LANES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CH_W-1:0]    r_ch_count;
    logic [CH_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]  r_base;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_lane [LANES];

    logic [CH_W-1:0]    w_remaining;
    logic [N_W-1:0]     w_n;
    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_accept;
    logic               w_grp_last;
    logic               w_tag_valid;
    logic [IDX_W-1:0]   w_tag_idx;
    logic               w_drained;

    assign w_remaining  = r_ch_count - r_cnt;
    assign w_n          = N_W'(min_lanes(32'(w_remaining), LANES));
    assign w_wr_fire    = (r_state == ST_WR) && s_valid && !abort;
    assign w_wr_last    = ({1'b0, r_cnt} + 1'b1) == {1'b0, r_ch_count};
    assign w_issue      = (r_state == ST_RD_ISSUE) && !abort;
    assign w_issue_last = (int'(r_idx) + 1) == int'(w_n);
    assign w_accept     = (r_state == ST_RD_HOLD) && bias_ready && !abort;
    assign w_grp_last   = ((CH_W+1)'(r_cnt) + (CH_W+1)'(w_n)) == (CH_W+1)'(r_ch_count);

    rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (w_issue),
        .push_idx  (r_idx),
        .out_valid (w_tag_valid),
        .out_idx   (w_tag_idx),
        .drained   (w_drained)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (ch_count == '0)          w_next = ST_DONE;
                    else if (mode == MODE_WRITE) w_next = ST_WR;
                    else                         w_next = ST_RD_ISSUE;
                end
            end
            ST_WR:       if (w_wr_fire && w_wr_last) w_next = ST_DONE;
            ST_RD_ISSUE: if (w_issue_last)           w_next = ST_RD_WAIT;
            ST_RD_WAIT:  if (w_drained)              w_next = ST_RD_HOLD;
            ST_RD_HOLD:  if (w_accept)               w_next = w_grp_last ? ST_DONE : ST_RD_ISSUE;
            ST_DONE:                                 w_next = ST_IDLE;
            default:                                 w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_comb begin
        s_ready    = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        bias_valid = 1'b0;
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        case (r_state)
            ST_WR: begin
                s_ready = (r_cnt < r_ch_count) && !abort;
                if (w_wr_fire) begin
                    bram_en    = 1'b1;
                    bram_we    = 1'b1;
                    bram_addr  = ADDR_W'(r_cnt);
                    bram_wdata = s_data;
                end
            end
            ST_RD_ISSUE: begin
                if (w_issue) begin
                    bram_en   = 1'b1;
                    bram_addr = r_base + ADDR_W'(r_idx);
                end
            end
            ST_RD_HOLD: bias_valid = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_count <= '0;
            r_cnt      <= '0;
            r_base     <= '0;
            r_idx      <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cnt  <= '0;
                r_base <= '0;
                r_idx  <= '0;
                if (start) r_ch_count <= ch_count;
            end
            if (w_wr_fire) r_cnt <= r_cnt + 1'b1;
            if (w_issue)   r_idx <= w_issue_last ? '0 : r_idx + 1'b1;
            if (w_accept) begin
                r_cnt  <= r_cnt + CH_W'(w_n);
                r_base <= r_base + ADDR_W'(w_n);
            end
            if (abort) r_idx <= '0;
        end
    end

    // First issue of a group clears every lane, so lanes beyond n read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
        end else begin
            if (w_issue && (r_idx == '0)) begin
                for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
            end
            if (w_tag_valid) r_lane[w_tag_idx] <= bram_rdata;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
            assign bias_vec[gi*DATA_W +: DATA_W] = r_lane[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bias_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bias_buffer_ctrl : directed self-checking bench with a 2-cycle BRAM model
// Rev 1.0
// ============================================================================
module tb_bias_buffer_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [11:0]  ch_count;
    logic         abort;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         bram_en;
    logic         bram_we;
    logic [8:0]   bram_addr;
    logic [31:0]  bram_wdata;
    logic [31:0]  bram_rdata;
    logic [127:0] bias_vec;
    logic         bias_valid;
    logic         bias_ready;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    // Job recorder state
    int           en_cnt, done_cnt, done_cyc, last_busy, vec_changes;
    int           grp_cyc [$];
    logic [127:0] grp_vec [$];
    logic [8:0]   rd_addr [$];

    always #5 clk = ~clk;

    bias_buffer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .ch_count   (ch_count),
        .abort      (abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .bias_vec   (bias_vec),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [31:0] pat(input int a);
        return 32'hB000_0000 | 32'(a & 511);
    endfunction

    // BRAM model: data appears RD_LAT=2 cycles after the enabled read, garbage otherwise.
    logic [31:0] rd_pipe0, rd_pipe1;
    always @(posedge clk) begin
        rd_pipe0 <= (bram_en && !bram_we) ? pat(int'(bram_addr)) : 32'hDEAD_BEEF;
        rd_pipe1 <= rd_pipe0;
    end
    assign bram_rdata = rd_pipe1;

    task automatic run_job(input logic md, input logic [11:0] ch, input int ready_from,
                           input int abort_at, input int ncyc);
        logic         pv;
        logic [127:0] hv;
        pv = 1'b0; hv = '0;
        en_cnt = 0; done_cnt = 0; done_cyc = -1; last_busy = -1; vec_changes = 0;
        grp_cyc.delete(); grp_vec.delete(); rd_addr.delete();
        @(negedge clk);
        start = 1'b1; mode = md; ch_count = ch; abort = 1'b0; s_valid = 1'b0;
        bias_ready = (ready_from <= 0);
        #1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            bias_ready = (c >= ready_from);
            abort = (c == abort_at);
            #1;
            if (bram_en) begin
                en_cnt++;
                if (!bram_we) rd_addr.push_back(bram_addr);
            end
            if (done) begin done_cnt++; done_cyc = c; end
            if (busy) last_busy = c;
            if (bias_valid && !pv) grp_cyc.push_back(c);
            if (bias_valid && pv && (bias_vec !== hv)) vec_changes++;
            if (bias_valid && bias_ready) grp_vec.push_back(bias_vec);
            pv = bias_valid;
            hv = bias_vec;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset;
        logic [176:0] outs;
        #1;
        outs = {s_ready, bram_en, bram_we, bram_addr, bram_wdata, bias_vec, bias_valid, busy, done};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h required 0", outs);
        end
    endtask

    task automatic test_write;
        int sent, nw, dcnt, dcyc;
        sent = 0; nw = 0; dcnt = 0; dcyc = -1;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; ch_count = 12'd5; s_valid = 1'b0; #1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start   = 1'b0;
            s_valid = (c != 2) && (c != 4);
            s_data  = 32'hD000_0000 + 32'(sent);
            #1;
            if (bram_en) begin
                n_tests++;
                if (!s_valid || !bram_we || bram_addr !== 9'(nw) ||
                    bram_wdata !== 32'hD000_0000 + 32'(nw)) begin
                    n_fail++;
                    $display("FAIL write_word%0d: cyc=%0d valid=%0b we=%0b addr=%0d data=%0h required we=1 addr=%0d data=%0h",
                             nw, c, s_valid, bram_we, bram_addr, bram_wdata, nw, 32'hD000_0000 + 32'(nw));
                end
                nw++;
            end
            if (s_valid && s_ready) sent++;
            if (done) begin dcnt++; dcyc = c; end
        end
        n_tests++;
        if (nw != 5 || sent != 5) begin
            n_fail++;
            $display("FAIL write_count: writes=%0d accepted=%0d required 5/5", nw, sent);
        end
        n_tests++;
        if (dcnt != 1 || dcyc != 8) begin
            n_fail++;
            $display("FAIL write_done: pulses=%0d cycle=%0d required 1 at 8", dcnt, dcyc);
        end
        n_tests++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle: s_ready=%0b busy=%0b required 0/0", s_ready, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_read_basic;
        run_job(1'b0, 12'd8, 0, -1, 20);
        n_tests++;
        if (grp_cyc.size() != 2 || grp_cyc[0] != 7 || grp_cyc[1] != 14) begin
            n_fail++;
            $display("FAIL read8_valid_cycles: groups=%0d first=%0d second=%0d required 2 at 7,14",
                     grp_cyc.size(), grp_cyc.size() > 0 ? grp_cyc[0] : -1, grp_cyc.size() > 1 ? grp_cyc[1] : -1);
        end
        n_tests++;
        if ((grp_vec.size() > 0 ? grp_vec[0] : 'x) !== {pat(3), pat(2), pat(1), pat(0)}) begin
            n_fail++;
            $display("FAIL read8_group0: got %0h required %0h",
                     grp_vec.size() > 0 ? grp_vec[0] : 'x, {pat(3), pat(2), pat(1), pat(0)});
        end
        n_tests++;
        if ((grp_vec.size() > 1 ? grp_vec[1] : 'x) !== {pat(7), pat(6), pat(5), pat(4)}) begin
            n_fail++;
            $display("FAIL read8_group1: got %0h required %0h",
                     grp_vec.size() > 1 ? grp_vec[1] : 'x, {pat(7), pat(6), pat(5), pat(4)});
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != 15 || last_busy != 15 || en_cnt != 8) begin
            n_fail++;
            $display("FAIL read8_done: pulses=%0d cycle=%0d last_busy=%0d reads=%0d required 1 at 15, 15, 8",
                     done_cnt, done_cyc, last_busy, en_cnt);
        end
    endtask

    task automatic test_read_backpressure;
        run_job(1'b0, 12'd6, 17, -1, 30);
        n_tests++;
        if (vec_changes != 0 || grp_cyc.size() != 2 || grp_cyc[0] != 7 || grp_cyc[1] != 22) begin
            n_fail++;
            $display("FAIL read6_stall: changes=%0d groups=%0d first=%0d second=%0d required 0, 2 at 7,22",
                     vec_changes, grp_cyc.size(), grp_cyc.size() > 0 ? grp_cyc[0] : -1,
                     grp_cyc.size() > 1 ? grp_cyc[1] : -1);
        end
        n_tests++;
        if ((grp_vec.size() > 0 ? grp_vec[0] : 'x) !== {pat(3), pat(2), pat(1), pat(0)}) begin
            n_fail++;
            $display("FAIL read6_group0: got %0h required %0h",
                     grp_vec.size() > 0 ? grp_vec[0] : 'x, {pat(3), pat(2), pat(1), pat(0)});
        end
        n_tests++;
        if ((grp_vec.size() > 1 ? grp_vec[1] : 'x) !== {32'h0, 32'h0, pat(5), pat(4)}) begin
            n_fail++;
            $display("FAIL read6_partial: got %0h required %0h",
                     grp_vec.size() > 1 ? grp_vec[1] : 'x, {32'h0, 32'h0, pat(5), pat(4)});
        end
        n_tests++;
        if (rd_addr.size() != 6 || rd_addr[4] !== 9'd4 || rd_addr[5] !== 9'd5 || done_cyc != 23) begin
            n_fail++;
            $display("FAIL read6_issues: reads=%0d done_cycle=%0d required 6 reads ending 4,5 and done 23",
                     rd_addr.size(), done_cyc);
        end
    endtask

    task automatic test_zero_count;
        for (int m = 0; m < 2; m++) begin
            run_job(m[0], 12'd0, 0, -1, 6);
            n_tests++;
            if (done_cnt != 1 || done_cyc != 1 || en_cnt != 0 || last_busy != 1) begin
                n_fail++;
                $display("FAIL zero_count_mode%0d: pulses=%0d cycle=%0d bram_en=%0d last_busy=%0d required 1 at 1, 0, 1",
                         m, done_cnt, done_cyc, en_cnt, last_busy);
            end
        end
    endtask

    task automatic test_abort;
        run_job(1'b0, 12'd8, 0, 5, 15);
        n_tests++;
        if (grp_cyc.size() != 0 || done_cnt != 0 || last_busy != 5 || en_cnt != 4) begin
            n_fail++;
            $display("FAIL abort_wait: groups=%0d done=%0d last_busy=%0d reads=%0d required 0, 0, 5, 4",
                     grp_cyc.size(), done_cnt, last_busy, en_cnt);
        end
        run_job(1'b0, 12'd4, 0, -1, 12);
        n_tests++;
        if (grp_cyc.size() != 1 || grp_cyc[0] != 7 || done_cyc != 8 ||
            (grp_vec.size() > 0 ? grp_vec[0] : 'x) !== {pat(3), pat(2), pat(1), pat(0)}) begin
            n_fail++;
            $display("FAIL abort_restart: groups=%0d done_cycle=%0d vec=%0h required 1 at 7, 8, %0h",
                     grp_cyc.size(), done_cyc, grp_vec.size() > 0 ? grp_vec[0] : 'x,
                     {pat(3), pat(2), pat(1), pat(0)});
        end
    endtask

    task automatic test_wrap_and_reset;
        int           bad;
        logic [176:0] outs;
        run_job(1'b0, 12'd515, 0, -1, 920);
        bad = 0;
        for (int i = 0; i < rd_addr.size(); i++)
            if (rd_addr[i] !== 9'(i % 512)) bad++;
        n_tests++;
        if (rd_addr.size() != 515 || bad != 0) begin
            n_fail++;
            $display("FAIL wrap_addresses: reads=%0d wrong=%0d required 515, 0", rd_addr.size(), bad);
        end
        n_tests++;
        if (grp_vec.size() != 129 || done_cnt != 1 || done_cyc != 903 ||
            (grp_vec.size() > 128 ? grp_vec[128] : 'x) !== {32'h0, pat(2), pat(1), pat(0)}) begin
            n_fail++;
            $display("FAIL wrap_last_group: groups=%0d done=%0d at %0d vec=%0h required 129, 1 at 903, %0h",
                     grp_vec.size(), done_cnt, done_cyc, grp_vec.size() > 128 ? grp_vec[128] : 'x,
                     {32'h0, pat(2), pat(1), pat(0)});
        end

        @(negedge clk);
        start = 1'b1; mode = 1'b0; ch_count = 12'd8; bias_ready = 1'b1; #1;
        @(negedge clk);
        start = 1'b0; #1;
        @(negedge clk);
        #1;
        n_tests++;
        if (bram_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_active: bram_en=%0b busy=%0b required 1/1", bram_en, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        outs = {s_ready, bram_en, bram_we, bram_addr, bram_wdata, bias_vec, bias_valid, busy, done};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %0h required 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; ch_count = '0; abort = 1'b0;
        s_data = '0; s_valid = 1'b0; bias_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_write;
        test_read_basic;
        test_read_backpressure;
        test_zero_count;
        test_abort;
        test_wrap_and_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
